reset_sequencer: RTL

Drives clean, active-low reset outputs for downstream logic: a minimum-width assertion followed by staged release, one output per domain. It is the driving end of the reset path. Its outputs feed blocks that filter or consume active-low resets, and its `req` input is driven by an already-filtered source, such as a debounced button or a software strobe. Power-on and requested resets follow one identical, cycle-exact sequence.

---
 rtl/reset_seq_pkg.sv | 34 +++
 rtl/rst_stage_timer.sv | 25 ++
 rtl/reset_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and elaboration-time helpers for the reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    RELEASE = 2'd2
  } seq_state_e;

  // A zero-width output vector makes no sense; force at least one output.
  function automatic int clamp_num_out(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  // The assertion must last at least one cycle.
  function automatic int clamp_assert_cycles(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  // Consecutive releases are at least one cycle apart.
  function automatic int clamp_stage_gap(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  // Counter must hold the larger terminal value; never narrower than 1 bit.
  function automatic int cnt_width(input int a, input int g);
    int m;
    int w;
    m = (a > g) ? a : g;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rst_stage_timer.sv
// Saturating up-counter with synchronous clear and a runtime terminal compare.
module rst_stage_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] terminal,
  output logic             hit
);

  logic [WIDTH-1:0] cnt_reg;

  // Count toward the terminal value and hold there until cleared.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt_reg <= '0;
    end else if (cnt_reg != terminal) begin
      cnt_reg <= cnt_reg + WIDTH'(1);
    end
  end

  assign hit = (cnt_reg == terminal);

endmodule

// File: rtl/reset_sequencer.sv
// Staged active-low reset generator: hold all outputs low, then release
// them one by one from bit 0 upward with a fixed gap between releases.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_OUT       = 4,
  parameter int ASSERT_CYCLES = 16,
  parameter int STAGE_GAP     = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              req,
  output logic [clamp_num_out(NUM_OUT)-1:0] rst_out_n,
  output logic                              busy,
  output logic                              done
);

  localparam int N       = clamp_num_out(NUM_OUT);
  localparam int A       = clamp_assert_cycles(ASSERT_CYCLES);
  localparam int G       = clamp_stage_gap(STAGE_GAP);
  localparam int CNT_W   = cnt_width(A, G);
  localparam int STAGE_W = $clog2(N + 1);

  localparam logic [CNT_W-1:0]   ASSERT_TERM = CNT_W'(A - 1);
  localparam logic [CNT_W-1:0]   GAP_TERM    = CNT_W'(G - 1);
  localparam logic [STAGE_W-1:0] LAST_STAGE  = STAGE_W'(N - 1);

  seq_state_e         state_reg, state_next;
  logic [STAGE_W-1:0] stage_reg, stage_next;
  logic [N-1:0]       out_reg, out_next;
  logic [N-1:0]       out_shifted;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic               timer_clear;
  logic [CNT_W-1:0]   timer_term;
  logic               timer_hit;

  // Releasing the next stage is a left shift that feeds a 1 into bit 0,
  // which keeps released bits contiguous from the bottom.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_shift
      if (gi == 0) begin : g_first
        assign out_shifted[gi] = 1'b1;
      end else begin : g_rest
        assign out_shifted[gi] = out_reg[gi-1];
      end
    end
  endgenerate

  assign timer_term = (state_reg == ASSERT) ? ASSERT_TERM : GAP_TERM;

  rst_stage_timer #(
    .WIDTH(CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .terminal(timer_term),
    .hit     (timer_hit)
  );

  // Next-state logic: a request always restarts the full sequence.
  always_comb begin
    state_next  = state_reg;
    stage_next  = stage_reg;
    out_next    = out_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;
    timer_clear = 1'b0;
    case (state_reg)
      IDLE: begin
        timer_clear = 1'b1;
        if (req) begin
          state_next = ASSERT;
          stage_next = '0;
          out_next   = '0;
          busy_next  = 1'b1;
        end
      end
      ASSERT: begin
        if (req) begin
          timer_clear = 1'b1;
          stage_next  = '0;
        end else if (timer_hit) begin
          timer_clear = 1'b1;
          out_next    = out_shifted;
          stage_next  = STAGE_W'(1);
          if (N == 1) begin
            state_next = IDLE;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end else begin
            state_next = RELEASE;
          end
        end
      end
      RELEASE: begin
        if (req) begin
          timer_clear = 1'b1;
          state_next  = ASSERT;
          stage_next  = '0;
          out_next    = '0;
        end else if (timer_hit) begin
          timer_clear = 1'b1;
          out_next    = out_shifted;
          stage_next  = stage_reg + STAGE_W'(1);
          if (stage_reg == LAST_STAGE) begin
            state_next = IDLE;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end
        end
      end
      default: begin
        timer_clear = 1'b1;
        state_next  = ASSERT;
        stage_next  = '0;
        out_next    = '0;
        busy_next   = 1'b1;
      end
    endcase
  end

  // State and output flops; reset lands in the same state as an accepted request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ASSERT;
      stage_reg <= '0;
      out_reg   <= '0;
      busy_reg  <= 1'b1;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      stage_reg <= stage_next;
      out_reg   <= out_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign rst_out_n = out_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule
